// File: rtl/fixed_point_iterative_complex_divider_if.sv
// Operand/result bundle for the iterative complex divider.
// Both sides use val/rdy: a transfer happens on a rising edge where val && rdy.
interface fixed_point_iterative_complex_divider_if #(
   parameter int n = 32
);
   logic         recv_val;
   logic         recv_rdy;
   logic         send_val;
   logic         send_rdy;
   logic [n-1:0] ar;
   logic [n-1:0] ac;
   logic [n-1:0] br;
   logic [n-1:0] bc;
   logic [n-1:0] cr;
   logic [n-1:0] cc;
   logic         div_zero;

   modport master (
      output recv_val, ar, ac, br, bc, send_rdy,
      input  recv_rdy, send_val, cr, cc, div_zero
   );

   modport slave (
      input  recv_val, ar, ac, br, bc, send_rdy,
      output recv_rdy, send_val, cr, cc, div_zero
   );
endinterface

// File: rtl/fixed_point_iterative_complex_divider.sv
// Fixed-point complex divide c = a / b using one shared signed multiplier
// and a one-bit-per-cycle restoring divider, sequenced by a small FSM.
module fixed_point_iterative_complex_divider #(
   parameter int n = 32,
   parameter int d = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   fixed_point_iterative_complex_divider_if.slave io,
   output logic [2:0]                            dbg_state
);
   localparam int N  = n + d + 1;
   localparam int CW = $clog2(N);

   typedef enum logic [2:0] {IDLE, MUL, DIVR, DIVI, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [n-1:0]    ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
   logic [n:0]      m_q, m_d;
   logic [n:0]      nr_q, nr_d, ni_q, ni_d;
   logic [n:0]      rem_q, rem_d;
   logic [N-1:0]    dq_q, dq_d;
   logic [n-1:0]    cr_q, cr_d, cc_q, cc_d;
   logic            dz_q, dz_d;

   logic signed [n-1:0]   mul_a, mul_b;
   logic signed [2*n-1:0] prod_full;
   logic [n-1:0]          prod;
   logic [n+1:0]          rem_shift, rem_sub;
   logic                  qbit;
   logic [N-1:0]          q_next;
   logic                  unused_bits;

   function automatic logic [n:0] mag(input logic [n:0] v);
      return v[n] ? -v : v;
   endfunction

   // Quotient magnitude is signed afterwards (truncation toward zero), then clamped.
   function automatic logic [n-1:0] sat_apply(input logic neg, input logic [N-1:0] q);
      logic [N-1:0] lim_pos;
      logic [N-1:0] lim_neg;
      logic [n-1:0] low;
      lim_pos = {{(N-n+1){1'b0}}, {(n-1){1'b1}}};
      lim_neg = {{(N-n){1'b0}}, 1'b1, {(n-1){1'b0}}};
      low     = q[n-1:0];
      if (!neg) return (q > lim_pos) ? {1'b0, {(n-1){1'b1}}} : low;
      return (q > lim_neg) ? {1'b1, {(n-1){1'b0}}} : -low;
   endfunction

   // Operand order for the shared multiplier follows the MUL step counter.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (cnt_q)
         CW'(0):  begin mul_a = br_q; mul_b = br_q; end
         CW'(1):  begin mul_a = bc_q; mul_b = bc_q; end
         CW'(2):  begin mul_a = ar_q; mul_b = br_q; end
         CW'(3):  begin mul_a = ac_q; mul_b = bc_q; end
         CW'(4):  begin mul_a = ac_q; mul_b = br_q; end
         default: begin mul_a = ar_q; mul_b = bc_q; end
      endcase
   end

   assign prod_full = mul_a * mul_b;
   assign prod      = prod_full[n+d-1:d];

   assign rem_shift = {rem_q, dq_q[N-1]};
   assign rem_sub   = rem_shift - {1'b0, m_q};
   assign qbit      = (rem_shift >= {1'b0, m_q});
   assign q_next    = {dq_q[N-2:0], qbit};

   assign unused_bits = ^{prod_full[2*n-1:n+d], prod_full[d-1:0], rem_sub[n+1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ar_d    = ar_q;
      ac_d    = ac_q;
      br_d    = br_q;
      bc_d    = bc_q;
      m_d     = m_q;
      nr_d    = nr_q;
      ni_d    = ni_q;
      rem_d   = rem_q;
      dq_d    = dq_q;
      cr_d    = cr_q;
      cc_d    = cc_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (io.recv_val) begin
               ar_d    = io.ar;
               ac_d    = io.ac;
               br_d    = io.br;
               bc_d    = io.bc;
               m_d     = '0;
               nr_d    = '0;
               ni_d    = '0;
               dz_d    = 1'b0;
               cnt_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            case (cnt_q)
               CW'(0), CW'(1): m_d  = m_q + {1'b0, prod};
               CW'(2), CW'(3): nr_d = nr_q + {prod[n-1], prod};
               CW'(4):         ni_d = ni_q + {prod[n-1], prod};
               default:        ni_d = ni_q - {prod[n-1], prod};
            endcase
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(5)) begin
               cnt_d = '0;
               if (m_q == '0) begin
                  cr_d    = '0;
                  cc_d    = '0;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  dq_d    = {mag(nr_q), {d{1'b0}}};
                  state_d = DIVR;
               end
            end
         end
         DIVR, DIVI: begin
            rem_d = qbit ? rem_sub[n:0] : rem_shift[n:0];
            dq_d  = q_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) begin
               cnt_d = '0;
               if (state_q == DIVR) begin
                  cr_d    = sat_apply(nr_q[n], q_next);
                  rem_d   = '0;
                  dq_d    = {mag(ni_q), {d{1'b0}}};
                  state_d = DIVI;
               end else begin
                  cc_d    = sat_apply(ni_q[n], q_next);
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (io.send_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ar_q    <= '0;
         ac_q    <= '0;
         br_q    <= '0;
         bc_q    <= '0;
         m_q     <= '0;
         nr_q    <= '0;
         ni_q    <= '0;
         rem_q   <= '0;
         dq_q    <= '0;
         cr_q    <= '0;
         cc_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ar_q    <= ar_d;
         ac_q    <= ac_d;
         br_q    <= br_d;
         bc_q    <= bc_d;
         m_q     <= m_d;
         nr_q    <= nr_d;
         ni_q    <= ni_d;
         rem_q   <= rem_d;
         dq_q    <= dq_d;
         cr_q    <= cr_d;
         cc_q    <= cc_d;
         dz_q    <= dz_d;
      end
   end

   assign io.recv_rdy = (state_q == IDLE);
   assign io.send_val = (state_q == DONE);
   assign io.cr       = cr_q;
   assign io.cc       = cc_q;
   assign io.div_zero = dz_q;
   assign dbg_state   = state_q;
endmodule

// File: tb/tb_fixed_point_iterative_complex_divider.sv
// Bench for the complex divider: directed cases from known quotients plus
// random operands checked against an integer-arithmetic reference model.
module tb_fixed_point_iterative_complex_divider;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int EW = 2*W + 1 + 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;

   fixed_point_iterative_complex_divider_if #(.n(W)) io();

   fixed_point_iterative_complex_divider #(.n(W), .d(D)) dut (
      .clk      (clk),
      .reset    (reset),
      .io       (io),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: multiply = floor((a*b) / 2^d) kept to W bits; divide = truncating
   // integer division of |num|*2^d by m, signed, clamped to the W-bit range.
   function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      p = p >>> D;
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] fdiv(input longint num, input longint m);
      longint q;
      q = ((num < 0) ? -num : num) * 65536 / m;
      if (num < 0) return (q > 64'sh8000_0000) ? 32'h8000_0000 : 32'(-q);
      return (q > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(q);
   endfunction

   task automatic push_exp(input logic [W-1:0] cr, input logic [W-1:0] cc, input logic dz,
                           input int lat);
      exp_q.push_back({cr, cc, dz, 16'(lat)});
   endtask

   task automatic model(input logic [W-1:0] ar, input logic [W-1:0] ac,
                        input logic [W-1:0] br, input logic [W-1:0] bc);
      longint m, nr, ni;
      m  = longint'({32'h0, fmul(br, br)}) + longint'({32'h0, fmul(bc, bc)});
      nr = longint'($signed(fmul(ar, br))) + longint'($signed(fmul(ac, bc)));
      ni = longint'($signed(fmul(ac, br))) - longint'($signed(fmul(ar, bc)));
      if (m == 0) push_exp('0, '0, 1'b1, 7);
      else        push_exp(fdiv(nr, m), fdiv(ni, m), 1'b0, 7 + 2*(W + D + 1));
   endtask

   task automatic run_txn(input logic [W-1:0] ar, input logic [W-1:0] ac,
                          input logic [W-1:0] br, input logic [W-1:0] bc, input int hold);
      int lat;
      logic [EW-1:0] e;
      logic [W-1:0] cr0, cc0;
      logic dz0;
      logic [2:0] st0;
      @(negedge clk);
      check("recv_rdy_idle", 64'(io.recv_rdy), 64'(1));
      io.ar = ar; io.ac = ac; io.br = br; io.bc = bc;
      io.recv_val = 1'b1;
      @(negedge clk);
      io.recv_val = 1'b0;
      io.ar = $urandom; io.ac = $urandom; io.br = $urandom; io.bc = $urandom;
      lat = 1;
      check("recv_rdy_busy", 64'(io.recv_rdy), 64'(0));
      check("div_zero_cleared", 64'(io.div_zero), 64'(0));
      while (!io.send_val && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      e = exp_q.pop_front();
      check("latency", 64'(lat), 64'(e[15:0]));
      check("cr", 64'(io.cr), 64'(e[80:49]));
      check("cc", 64'(io.cc), 64'(e[48:17]));
      check("div_zero", 64'(io.div_zero), 64'(e[16]));
      cr0 = io.cr; cc0 = io.cc; dz0 = io.div_zero; st0 = dbg_state;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_send_val", 64'(io.send_val), 64'(1));
         check("hold_recv_rdy", 64'(io.recv_rdy), 64'(0));
         check("hold_result", {io.cr, io.cc}, {cr0, cc0});
         check("hold_dz_state", {60'h0, io.div_zero, dbg_state}, {60'h0, dz0, st0});
      end
      io.send_rdy = 1'b1;
      @(negedge clk);
      io.send_rdy = 1'b0;
      check("send_val_drop", 64'(io.send_val), 64'(0));
      check("recv_rdy_back", 64'(io.recv_rdy), 64'(1));
   endtask

   function automatic logic [W-1:0] small_val();
      return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
   endfunction

   initial begin
      logic seen;
      logic [W-1:0] ar, ac, br, bc;
      reset = 1'b0;
      io.recv_val = 1'b0; io.send_rdy = 1'b0;
      io.ar = '0; io.ac = '0; io.br = '0; io.bc = '0;
      repeat (3) @(negedge clk);
      check("rst_recv_rdy", 64'(io.recv_rdy), 64'(1));
      check("rst_send_val", 64'(io.send_val), 64'(0));
      check("rst_outputs", {31'h0, io.div_zero, io.cr | io.cc}, 64'(0));
      reset = 1'b1;

      push_exp(32'h0000_8000, 32'h0, 1'b0, 105);
      run_txn(32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0, 0);
      push_exp(32'h0000_0000, 32'h0001_0000, 1'b0, 105);
      run_txn(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 0);
      push_exp(32'hFFFF_8000, 32'h0, 1'b0, 105);
      run_txn(32'hFFFF_0000, 32'h0, 32'h0002_0000, 32'h0, 0);
      push_exp(32'h0, 32'h0, 1'b1, 7);
      run_txn($urandom, $urandom, 32'h0, 32'h0, 0);
      push_exp(32'h0000_8000, 32'h0, 1'b0, 105);
      run_txn(32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0, 0);
      push_exp(32'h7FFF_FFFF, 32'h0, 1'b0, 105);
      run_txn(32'h7FFF_0000, 32'h0, 32'h0000_0100, 32'h0, 20);

      for (int i = 0; i < 12; i++) begin
         if (i < 6) begin
            ar = small_val(); ac = small_val(); br = small_val(); bc = small_val();
         end else begin
            ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom;
         end
         model(ar, ac, br, bc);
         run_txn(ar, ac, br, bc, $urandom_range(0, 3));
      end

      // Abort a computation partway through the real-part division.
      push_exp(32'h7FFF_FFFF, 32'h0, 1'b0, 105);
      run_txn(32'h7FFF_0000, 32'h0, 32'h0000_0100, 32'h0, 0);
      @(negedge clk);
      io.ar = 32'h0001_0000; io.ac = 32'h0; io.br = 32'h0002_0000; io.bc = 32'h0;
      io.recv_val = 1'b1;
      @(negedge clk);
      io.recv_val = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_recv_rdy", 64'(io.recv_rdy), 64'(1));
      check("abort_send_val", 64'(io.send_val), 64'(0));
      check("abort_cr", 64'(io.cr), 64'(0));
      check("abort_cc_dz", {31'h0, io.div_zero, io.cc}, 64'(0));
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (io.send_val) seen = 1'b1;
      end
      check("abort_no_result", 64'(seen), 64'(0));

      push_exp(32'hFFFF_8000, 32'h0, 1'b0, 105);
      run_txn(32'hFFFF_0000, 32'h0, 32'h0002_0000, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
